// File: rtl/vctcxo_dac_pkg.sv
// rtl/vctcxo_dac_pkg.sv - shared types and constants for the VCTCXO trim DAC scheduler
package vctcxo_dac_pkg;

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SHIFT, ST_GAP} state_t;

   localparam int         FRAME_BITS = 24;
   localparam logic [1:0] PD_NORMAL  = 2'b00;

   function automatic logic [FRAME_BITS-1:0] make_frame(input logic [15:0] code);
      return {6'b0, PD_NORMAL, code};
   endfunction

endpackage

// File: rtl/dac_spi_shifter.sv
// rtl/dac_spi_shifter.sv - serialises one 24-bit DAC frame, MSB first, data stable on sclk falling edges
module dac_spi_shifter
   import vctcxo_dac_pkg::*;
#(
   parameter int SCLK_HALF = 2
) (
   input  logic                  refclk,
   input  logic                  reset,
   input  logic                  i_load,
   input  logic [FRAME_BITS-1:0] i_frame,
   output logic                  o_sclk,
   output logic                  o_mosi,
   output logic                  o_sync_n,
   output logic                  o_done
);

   localparam logic [3:0] DIV_LAST = 4'(SCLK_HALF - 1);
   localparam logic [5:0] PH_LAST  = 6'(2 * FRAME_BITS);

   logic                  r_active;
   logic [3:0]            r_div;
   logic [5:0]            r_phase;
   logic [FRAME_BITS-2:0] r_sr;
   logic                  w_tick;

   assign w_tick = r_active && (r_div == DIV_LAST);
   assign o_done = w_tick && (r_phase == PH_LAST);

   // Phase 0 is the setup half; each later phase boundary toggles sclk, even boundaries rise.
   always_ff @(posedge refclk) begin
      if (reset) begin
         r_active <= 1'b0;
         r_div    <= '0;
         r_phase  <= '0;
         r_sr     <= '0;
         o_sclk   <= 1'b0;
         o_mosi   <= 1'b0;
         o_sync_n <= 1'b1;
      end else if (i_load && !r_active) begin
         r_active <= 1'b1;
         r_div    <= '0;
         r_phase  <= '0;
         r_sr     <= i_frame[FRAME_BITS-2:0];
         o_sclk   <= 1'b0;
         o_mosi   <= i_frame[FRAME_BITS-1];
         o_sync_n <= 1'b0;
      end else if (r_active) begin
         if (!w_tick) begin
            r_div <= r_div + 4'd1;
         end else begin
            r_div <= '0;
            if (r_phase == PH_LAST) begin
               r_active <= 1'b0;
               o_sync_n <= 1'b1;
               o_mosi   <= 1'b0;
            end else begin
               r_phase <= r_phase + 6'd1;
               o_sclk  <= ~r_phase[0];
               // The first rising edge keeps the MSB; later rising edges advance the data.
               if (!r_phase[0] && (r_phase != 6'd0)) begin
                  o_mosi <= r_sr[FRAME_BITS-2];
                  r_sr   <= {r_sr[FRAME_BITS-3:0], 1'b0};
               end
            end
         end
      end
   end

endmodule

// File: rtl/vctcxo_dac_scheduler.sv
// rtl/vctcxo_dac_scheduler.sv - arbitrates PLL loop and host trim codes onto the shared VCTCXO DAC
module vctcxo_dac_scheduler
   import vctcxo_dac_pkg::*;
#(
   parameter logic [15:0] INIT_VAL  = 16'd32767,
   parameter int          SCLK_HALF = 2,
   parameter int          SYNC_HIGH = 4
) (
   input  logic        refclk,
   input  logic        reset,
   input  logic        i_manual,
   input  logic [15:0] i_loop_dat,
   input  logic        i_loop_valid,
   input  logic [15:0] i_host_dat,
   input  logic        i_host_valid,
   output logic        o_host_ready,
   output logic        o_sclk,
   output logic        o_mosi,
   output logic        o_sync_n,
   output logic        o_busy,
   output logic [15:0] o_cur_val,
   output logic [15:0] o_loop_drops
);

   localparam logic [7:0] GAP_LAST = 8'(SYNC_HIGH - 1);

   state_t      r_state;
   logic        r_busy;
   logic        r_load;
   logic [15:0] r_code;
   logic [15:0] r_cur_val;
   logic [15:0] r_drops;
   logic [15:0] r_loop_dat;
   logic        r_loop_pend;
   logic        r_manual_d;
   logic [7:0]  r_gap;

   logic        w_idle;
   logic        w_manual_fall;
   logic        w_host_go;
   logic        w_loop_go;
   logic [15:0] w_sel;
   logic        w_launch;
   logic        w_drop;
   logic        w_done;

   assign w_idle        = (r_state == ST_IDLE);
   assign w_manual_fall = r_manual_d & ~i_manual;
   assign w_host_go     = w_idle & i_host_valid;
   // A value pending across a manual period is stale the moment manual drops.
   assign w_loop_go     = w_idle & ~i_host_valid & r_loop_pend & ~i_manual & ~w_manual_fall;
   assign w_sel         = w_host_go ? i_host_dat : r_loop_dat;
   assign w_launch      = (w_host_go | w_loop_go) & (w_sel != r_cur_val);
   assign w_drop        = i_loop_valid & (i_manual | (r_loop_pend & ~w_loop_go & ~w_manual_fall));

   assign o_host_ready  = w_idle & ~(w_loop_go & (r_loop_dat != r_cur_val));
   assign o_busy        = r_busy;
   assign o_cur_val     = r_cur_val;
   assign o_loop_drops  = r_drops;

   always_ff @(posedge refclk) begin
      if (reset) begin
         r_loop_pend <= 1'b0;
         r_loop_dat  <= '0;
         r_drops     <= '0;
         r_manual_d  <= 1'b0;
      end else begin
         r_manual_d <= i_manual;
         if (i_loop_valid && !i_manual) begin
            r_loop_pend <= 1'b1;
            r_loop_dat  <= i_loop_dat;
         end else if (w_loop_go || w_manual_fall) begin
            r_loop_pend <= 1'b0;
         end
         if (w_drop && (r_drops != 16'hFFFF))
            r_drops <= r_drops + 16'd1;
      end
   end

   always_ff @(posedge refclk) begin
      if (reset) begin
         r_state   <= ST_INIT;
         r_busy    <= 1'b1;
         r_load    <= 1'b0;
         r_code    <= INIT_VAL;
         r_cur_val <= INIT_VAL;
         r_gap     <= '0;
      end else begin
         r_load <= 1'b0;
         unique case (r_state)
            ST_INIT: begin
               r_load  <= 1'b1;
               r_code  <= INIT_VAL;
               r_state <= ST_SHIFT;
            end
            ST_IDLE: begin
               if (w_launch) begin
                  r_load  <= 1'b1;
                  r_code  <= w_sel;
                  r_busy  <= 1'b1;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (w_done) begin
                  r_cur_val <= r_code;
                  r_gap     <= '0;
                  r_state   <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (r_gap == GAP_LAST) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_gap <= r_gap + 8'd1;
               end
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

   dac_spi_shifter #(
      .SCLK_HALF(SCLK_HALF)
   ) u_shifter (
      .refclk  (refclk),
      .reset   (reset),
      .i_load  (r_load),
      .i_frame (make_frame(r_code)),
      .o_sclk  (o_sclk),
      .o_mosi  (o_mosi),
      .o_sync_n(o_sync_n),
      .o_done  (w_done)
   );

endmodule

// File: tb/tb_vctcxo_dac_scheduler.sv
// tb/tb_vctcxo_dac_scheduler.sv - bench for the VCTCXO DAC scheduler
module tb_vctcxo_dac_scheduler;

   localparam logic [15:0] INIT_VAL  = 16'h7FFF;
   localparam int          SCLK_HALF = 2;
   localparam int          SYNC_HIGH = 4;

   logic        refclk = 1'b0;
   logic        reset = 1'b1;
   logic        i_manual = 1'b0;
   logic [15:0] i_loop_dat = '0;
   logic        i_loop_valid = 1'b0;
   logic [15:0] i_host_dat = '0;
   logic        i_host_valid = 1'b0;
   logic        o_host_ready, o_sclk, o_mosi, o_sync_n, o_busy;
   logic [15:0] o_cur_val, o_loop_drops;

   vctcxo_dac_scheduler #(
      .INIT_VAL(INIT_VAL), .SCLK_HALF(SCLK_HALF), .SYNC_HIGH(SYNC_HIGH)
   ) dut (
      .refclk(refclk), .reset(reset), .i_manual(i_manual),
      .i_loop_dat(i_loop_dat), .i_loop_valid(i_loop_valid),
      .i_host_dat(i_host_dat), .i_host_valid(i_host_valid), .o_host_ready(o_host_ready),
      .o_sclk(o_sclk), .o_mosi(o_mosi), .o_sync_n(o_sync_n), .o_busy(o_busy),
      .o_cur_val(o_cur_val), .o_loop_drops(o_loop_drops)
   );

   always #5 refclk = ~refclk;

   typedef struct {
      logic [23:0] data;
      int          bits;
      int          low;
      int          rises;
   } frame_t;

   typedef struct {
      logic        man;
      logic        lv;
      logic [15:0] ld;
      logic        hv;
      logic [15:0] hd;
      logic        ef;
      logic [15:0] ec;
      logic [15:0] edrops;
   } vec_t;

   frame_t      obs_q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          gap_cnt = 0;
   bit          gap_on = 0;
   logic        m_prev_sclk = 1'b0;
   logic        m_prev_sync = 1'b1;
   logic [23:0] m_sh = '0;
   int          m_bits = 0, m_low = 0, m_rises = 0;

   // Pin-level decoder: DAC view of each frame, sampled on sclk falling edges.
   always @(negedge refclk) begin
      if (!o_sync_n) begin
         if (m_prev_sync) begin
            m_sh = '0; m_bits = 0; m_low = 0; m_rises = 0;
         end
         m_low++;
         if (!m_prev_sclk && o_sclk) m_rises++;
         if (m_prev_sclk && !o_sclk) begin
            m_sh = {m_sh[22:0], o_mosi};
            m_bits++;
         end
      end else if (!m_prev_sync) begin
         obs_q.push_back('{data: m_sh, bits: m_bits, low: m_low, rises: m_rises});
         gap_cnt = o_busy ? 1 : 0;
         gap_on  = 1;
      end else if (gap_on) begin
         if (o_busy) gap_cnt++;
         else gap_on = 0;
      end
      m_prev_sclk = o_sclk;
      m_prev_sync = o_sync_n;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic loop_strobe(input logic [15:0] v);
      i_loop_dat   = v;
      i_loop_valid = 1'b1;
      tick();
      i_loop_valid = 1'b0;
   endtask

   task automatic host_req(input logic [15:0] v);
      bit ok = 0;
      i_host_dat   = v;
      i_host_valid = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge refclk);
         if (o_host_ready) begin
            ok = 1;
            break;
         end
      end
      chk("host_ready", 32'(ok), 32'd1);
      tick();
      i_host_valid = 1'b0;
   endtask

   task automatic settle();
      int quiet = 0;
      for (int i = 0; i < 3000 && quiet < 8; i++) begin
         @(negedge refclk);
         if (!o_busy) quiet++;
         else quiet = 0;
      end
      chk("settle_idle", 32'(quiet >= 8), 32'd1);
      tick();
   endtask

   task automatic wait_sync_low();
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge refclk);
         if (!o_sync_n) begin
            ok = 1;
            break;
         end
      end
      chk("sync_low_seen", 32'(ok), 32'd1);
      tick();
   endtask

   task automatic expect_frame(input string name, input logic [15:0] code, output frame_t f);
      f = '{data: '0, bits: 0, low: 0, rises: 0};
      if (obs_q.size() == 0) begin
         chk({name, "_present"}, 32'd0, 32'd1);
      end else begin
         f = obs_q.pop_front();
         chk(name, 32'(f.data), {8'h00, 8'h00, code});
      end
   endtask

   task automatic expect_none(input string name);
      chk(name, 32'(obs_q.size()), 32'd0);
   endtask

   vec_t        tbl[8];
   frame_t      f;
   logic [15:0] exp_cur, exp_drops, v, last;
   logic [15:0] exp_q[$];

   initial begin
      tbl[0] = '{1'b0, 1'b1, 16'h8000, 1'b0, 16'h0000, 1'b1, 16'h8000, 16'd0};
      tbl[1] = '{1'b0, 1'b1, 16'h8000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd0};
      tbl[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h8000, 1'b0, 16'h0000, 16'd0};
      tbl[3] = '{1'b1, 1'b1, 16'h5555, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd1};
      tbl[4] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b1, 16'h0100, 16'd1};
      tbl[5] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0FFF, 1'b1, 16'h0FFF, 16'd1};
      tbl[6] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'd1};
      tbl[7] = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'd1};

      repeat (4) tick();
      @(negedge refclk);
      chk("rst_sclk", 32'(o_sclk), 32'd0);
      chk("rst_mosi", 32'(o_mosi), 32'd0);
      chk("rst_sync_n", 32'(o_sync_n), 32'd1);
      chk("rst_busy", 32'(o_busy), 32'd1);
      chk("rst_host_ready", 32'(o_host_ready), 32'd0);
      chk("rst_cur_val", 32'(o_cur_val), 32'(INIT_VAL));
      chk("rst_drops", 32'(o_loop_drops), 32'd0);
      tick();
      reset = 1'b0;

      settle();
      expect_frame("init_code", INIT_VAL, f);
      chk("init_bits", 32'(f.bits), 32'd24);
      chk("init_rises", 32'(f.rises), 32'd24);
      chk("init_low", 32'(f.low), 32'(49 * SCLK_HALF));
      chk("init_gap", 32'(gap_cnt), 32'(SYNC_HIGH));
      chk("init_cur_val", 32'(o_cur_val), 32'(INIT_VAL));
      exp_cur   = INIT_VAL;
      exp_drops = 16'd0;

      for (int i = 0; i < 8; i++) begin
         i_manual = tbl[i].man;
         tick();
         if (tbl[i].lv) loop_strobe(tbl[i].ld);
         if (tbl[i].hv) host_req(tbl[i].hd);
         settle();
         if (tbl[i].ef) begin
            expect_frame($sformatf("vec%0d_code", i), tbl[i].ec, f);
            exp_cur = tbl[i].ec;
         end
         expect_none($sformatf("vec%0d_extra", i));
         chk($sformatf("vec%0d_cur", i), 32'(o_cur_val), 32'(exp_cur));
         chk($sformatf("vec%0d_drops", i), 32'(o_loop_drops), 32'(tbl[i].edrops));
      end
      i_manual  = 1'b0;
      exp_drops = 16'd1;

      // Loop value pending when manual rises must be discarded when manual falls.
      host_req(16'h4444);
      wait_sync_low();
      loop_strobe(16'h7777);
      i_manual = 1'b1;
      settle();
      expect_frame("stale_first", 16'h4444, f);
      expect_none("stale_held");
      host_req(16'h0100);
      settle();
      expect_frame("manual_host", 16'h0100, f);
      i_manual = 1'b0;
      settle();
      repeat (60) tick();
      expect_none("stale_cleared");
      chk("stale_cur", 32'(o_cur_val), 32'h0100);
      chk("stale_drops", 32'(o_loop_drops), 32'(exp_drops));

      host_req(16'h4444);
      wait_sync_low();
      loop_strobe(16'h1000); repeat (2) tick();
      loop_strobe(16'h2000); repeat (2) tick();
      loop_strobe(16'h3000);
      settle();
      expect_frame("burst_first", 16'h4444, f);
      expect_frame("burst_latest", 16'h3000, f);
      exp_drops = exp_drops + 16'd2;
      chk("burst_drops", 32'(o_loop_drops), 32'(exp_drops));

      i_host_dat   = 16'hABCD;
      i_host_valid = 1'b1;
      i_loop_dat   = 16'h1234;
      i_loop_valid = 1'b1;
      @(negedge refclk);
      chk("both_ready", 32'(o_host_ready), 32'd1);
      tick();
      i_host_valid = 1'b0;
      i_loop_valid = 1'b0;
      settle();
      expect_frame("both_host", 16'hABCD, f);
      expect_frame("both_loop", 16'h1234, f);
      chk("both_drops", 32'(o_loop_drops), 32'(exp_drops));

      host_req(16'h2222);
      wait_sync_low();
      begin
         int   rises = 0;
         logic prev = 1'b0;
         for (int i = 0; i < 300 && rises < 10; i++) begin
            @(negedge refclk);
            if (!prev && o_sclk) rises++;
            prev = o_sclk;
         end
         chk("abort_edge10", 32'(rises), 32'd10);
      end
      reset = 1'b1;
      @(negedge refclk);
      chk("abort_sync_n", 32'(o_sync_n), 32'd1);
      chk("abort_sclk", 32'(o_sclk), 32'd0);
      chk("abort_cur", 32'(o_cur_val), 32'(INIT_VAL));
      tick();
      reset = 1'b0;
      obs_q.delete();
      settle();
      expect_frame("abort_init", INIT_VAL, f);
      chk("abort_init_low", 32'(f.low), 32'(49 * SCLK_HALF));
      chk("abort_drops", 32'(o_loop_drops), 32'd0);
      exp_cur   = INIT_VAL;
      exp_drops = 16'd0;

      // Randomised rounds against an intent-level model: code sequence, cur_val, drop count.
      for (int r = 0; r < 40; r++) begin
         int kind = $urandom_range(0, 3);
         v = ($urandom_range(0, 3) == 0) ? exp_cur : 16'($urandom);
         case (kind)
            0: begin
               loop_strobe(v);
               if (v != exp_cur) begin exp_q.push_back(v); exp_cur = v; end
            end
            1: begin
               i_manual = 1'($urandom_range(0, 1));
               tick();
               host_req(v);
               if (v != exp_cur) begin exp_q.push_back(v); exp_cur = v; end
            end
            2: begin
               i_manual = 1'b1;
               tick();
               loop_strobe(v);
               exp_drops = exp_drops + 16'd1;
            end
            default: begin
               int k = $urandom_range(1, 3);
               v = exp_cur ^ 16'($urandom_range(1, 65535));
               host_req(v);
               exp_q.push_back(v);
               exp_cur = v;
               wait_sync_low();
               for (int j = 0; j < k; j++) begin
                  last = ($urandom_range(0, 3) == 0) ? v : 16'($urandom);
                  loop_strobe(last);
                  repeat (2) tick();
               end
               exp_drops = exp_drops + 16'(k - 1);
               if (last != exp_cur) begin exp_q.push_back(last); exp_cur = last; end
            end
         endcase
         i_manual = 1'b0;
         settle();
         while (exp_q.size() > 0)
            expect_frame($sformatf("rnd%0d_code", r), exp_q.pop_front(), f);
         expect_none($sformatf("rnd%0d_extra", r));
         chk($sformatf("rnd%0d_cur", r), 32'(o_cur_val), 32'(exp_cur));
         chk($sformatf("rnd%0d_drops", r), 32'(o_loop_drops), 32'(exp_drops));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vctcxo_dac_scheduler.md
Name: vctcxo_dac_scheduler

Overview:
- Owns the VCTCXO trim DAC (AD5662-class, 24-bit SPI frame).
- Shares the DAC between two requesters: the reference PLL loop and the host (manual trim/override). Arbitrates and serialises their writes onto one SPI link.
- Writes a power-on default after reset and suppresses redundant writes.
- Sits between the ref PLL / host register file and the DAC pins, replacing the PLL's private free-running SPI driver.

Parameters:
- INIT_VAL, 16'd32767, DAC code written once after reset.
- SCLK_HALF, 2, sclk half-period in refclk cycles (2 gives 10 MHz sclk from 40 MHz); legal range 1..15.
- SYNC_HIGH, 4, minimum refclk cycles sync_n stays high between frames.

Ports:
- refclk  in  1  clock (40 MHz reference).
- reset  in  1  synchronous, active-high.
- manual  in  1  1 = host override; loop requests are dropped.
- loop_dat  in  16  PLL loop DAC code (already synchronised to refclk).
- loop_valid  in  1  1-cycle strobe; loop_dat is valid this cycle.
- host_dat  in  16  host DAC code.
- host_valid  in  1  host request (valid/ready handshake).
- host_ready  out  1  host request accepted this cycle.
- sclk  out  1  SPI clock.
- mosi  out  1  SPI data.
- sync_n  out  1  SPI frame select, active low.
- busy  out  1  frame in progress (INIT, SHIFT or GAP).
- cur_val  out  16  last code fully shifted to the DAC.
- loop_drops  out  16  saturating count of loop strobes lost (overwritten or dropped in manual).

Behaviour:
- Interface: reset is synchronous, active-high; the clock is refclk. All I/O is synchronous to refclk.
- Reset values: sclk=0, mosi=0, sync_n=1, busy=1, host_ready=0, cur_val=INIT_VAL, loop_drops=0, both pending flags=0, state=INIT.
- Loop mailbox: a single entry.
  - loop_valid with mailbox empty: store the value, set pending.
  - loop_valid with mailbox full: overwrite (latest wins), loop_drops+1.
  - loop_valid while manual=1: discard, loop_drops+1.
  - On a 1 to 0 transition of manual, any pending loop value is cleared (stale).
- Host: host_ready=1 only in IDLE when no frame is being launched from the loop that cycle. The transfer occurs when host_valid & host_ready.
- Arbitration in IDLE, evaluated each cycle:
  - host transfer wins;
  - else a pending loop value when manual=0;
  - else stay in IDLE.
  - If host and loop are both present, the host is served and the loop value stays pending.
- Redundancy: if the selected code equals cur_val, no frame is sent. The request is consumed; the loop pending flag clears, or host_ready still pulses.
- States:
  - INIT: load the INIT_VAL frame, go to SHIFT.
  - IDLE: arbitrate; on a grant, load the 24-bit frame {6'b0, 2'b00 (normal PD mode), code} and go to SHIFT.
  - SHIFT: sync_n=0.
    - mosi presents the MSB first, changing on sclk rising edges; the DAC samples on sclk falling edges.
    - One SCLK_HALF setup period precedes the first rising edge.
    - 24 full sclk periods; sclk returns to 0 at the end.
    - Frame length = (1 + 48) × SCLK_HALF refclk cycles.
  - GAP: sync_n=1, cur_val updates on entry, wait SYNC_HIGH cycles, then IDLE.
- busy=0 only in IDLE.
- Requests arriving during SHIFT/GAP wait in the mailbox (loop) or by holding host_valid (host).
- loop_drops saturates at 16'hFFFF.
- Reset mid-frame: sync_n goes high on the next edge, the frame is aborted, and INIT_VAL is rewritten.
- manual changing mid-frame does not affect the current frame.

Decomposition:
- Shared package vctcxo_dac_pkg:
  - state encoding (INIT, IDLE, SHIFT, GAP);
  - FRAME_BITS=24;
  - PD_NORMAL=2'b00.
- One sub-module, dac_spi_shifter: load/code in; sclk/mosi/sync_n/done out; SCLK_HALF parameter.
- The scheduler holds the arbiter, the mailbox and the FSM.

Test Plan:
- Reset release -> one frame carries 0x007FFF. Check sync_n low for 49×2=98 cycles, 24 sclk rising edges, then cur_val=0x7FFF and busy falls after SYNC_HIGH.
- loop_valid with 0x8000 while manual=0 -> one frame carrying 0x008000; cur_val=0x8000.
- loop_valid with 0x8000 -> no frame; the pending flag clears in one cycle.
- Three loop_valid strobes (0x1000, 0x2000, 0x3000) during a frame -> the next frame carries 0x3000 and loop_drops=2.
- host_valid 0xABCD asserted in the same cycle as loop_valid 0x1234 -> frames in order 0xABCD then 0x1234.
- manual=1:
  - loop_valid 0x5555 -> no frame, loop_drops+1;
  - host 0x0100 -> frame sent.
  - Then manual=0 -> no stale loop frame.
- Reset asserted at sclk edge 10 of a frame -> sync_n high next cycle, then an INIT_VAL frame follows.
